// File: rtl/s_mem_pkg.sv
// Shared types and defaults for the working-memory read port.
package s_mem_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  // Identifies which of the two client FSMs owns a read.
  typedef logic client_id_t;

  // One slot of the in-flight read pipeline.
  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rd_tag_t;

  localparam rd_tag_t TagIdle = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered fairness pointer.
module rr_arb2
  import s_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt,
  output logic       contested
);

  client_id_t ptr_q, ptr_d;

  // Grant decode; the pointer only breaks ties when both clients ask.
  always_comb begin
    gnt       = 2'b00;
    contested = 1'b0;
    if (!hold) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          contested = 1'b1;
          gnt       = ptr_q ? 2'b10 : 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pass priority to the loser of a contested grant; uncontested grants leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (contested) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register, client 0 favoured out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/s_mem_read_port.sv
// Two-client read arbiter and responder for the 256x8 working memory.
module s_mem_read_port
  import s_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  // Slot 0 is loaded as mem_addr is; slot RD_LAT lines up with mem_q.
  localparam int TagDepth = int'(RD_LAT) + 1;

  logic [1:0]        gnt;
  logic              accept;
  client_id_t        gnt_id;
  logic              unused_contested;
  logic [ADDR_W-1:0] mem_addr_q;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  rd_tag_t           tag_q [TagDepth];
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              busy_c;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1, req0}),
    .hold      (hold),
    .gnt       (gnt),
    .contested (unused_contested)
  );

  assign accept = |gnt;
  assign gnt_id = gnt[1];
  assign tag_in = '{valid: accept, id: gnt_id};

  // RAM address register; holds its last value between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
    end else if (accept) begin
      mem_addr_q <= gnt_id ? addr1 : addr0;
    end
  end

  // Tag shift register tracking which client owns each read in the RAM pipeline.
  for (genvar i = 0; i < TagDepth; i++) begin : g_tag
    if (i == 0) begin : g_head
      // Head slot records this cycle's accept (or a bubble).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q[i] <= TagIdle;
        end else begin
          tag_q[i] <= tag_in;
        end
      end
    end else begin : g_body
      // Later slots simply age the tag by one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q[i] <= TagIdle;
        end else begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign tag_out = tag_q[TagDepth-1];

  // Response demux: steer mem_q to the owning client, the other keeps its byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tag_out.valid && !tag_out.id;
      rvalid1_q <= tag_out.valid && tag_out.id;
      if (tag_out.valid && !tag_out.id) begin
        rdata0_q <= mem_q;
      end
      if (tag_out.valid && tag_out.id) begin
        rdata1_q <= mem_q;
      end
    end
  end

  // Busy while any accepted read is in the pipeline or its rvalid is still showing.
  always_comb begin
    busy_c = rvalid0_q | rvalid1_q;
    for (int k = 0; k < TagDepth; k++) begin
      busy_c = busy_c | tag_q[k].valid;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign mem_addr = mem_addr_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = busy_c;

endmodule

// File: tb/tb_s_mem_read_port.sv
// Directed bench for s_mem_read_port: default latency DUT plus an RD_LAT=2 build.
module tb_s_mem_read_port;

  logic       clk;
  logic       rst_n;
  logic       hold, req0, req1;
  logic [7:0] addr0, addr1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata0, rdata1, mem_addr, mem_q;

  logic       hold_b, req0_b, req1_b;
  logic [7:0] addr0_b, addr1_b;
  logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b;
  logic [7:0] rdata0_b, rdata1_b, mem_addr_b, mem_q_b, q_b1;

  logic [7:0] ram [256];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of outstanding reads (accepted 1, 2, 3 cycles ago).
  logic [2:0] pv, pid;
  logic [7:0] pd [3];
  logic       pend_v, pend_id;
  logic [7:0] pend_d;
  logic [7:0] e_rd0, e_rd1;
  logic       e_g0, e_g1;

  logic [20:0] obs_vec, exp_vec;
  assign obs_vec = {gnt0, gnt1, rvalid0, rvalid1, busy, rdata0, rdata1};
  assign exp_vec = {e_g0, e_g1, pv[2] & ~pid[2], pv[2] & pid[2], |pv, e_rd0, e_rd1};

  s_mem_read_port #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_q(mem_q), .busy(busy)
  );

  s_mem_read_port #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hold(hold_b),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_q(mem_q_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models: one and two cycles of read latency.
  always @(posedge clk) mem_q <= ram[mem_addr];
  always @(posedge clk) begin
    q_b1    <= ram[mem_addr_b];
    mem_q_b <= q_b1;
  end

  task automatic model_clear();
    pv = '0; pid = '0;
    for (int k = 0; k < 3; k++) pd[k] = '0;
    pend_v = 1'b0; pend_id = 1'b0; pend_d = '0;
    e_rd0 = '0; e_rd1 = '0; e_g0 = 1'b0; e_g1 = 1'b0;
  endtask

  // Advance one cycle: age the model, drive inputs, stop at the sample point.
  task automatic cycle(input logic r0, input logic [7:0] a0, input logic r1,
                       input logic [7:0] a1, input logic h, input logic g0, input logic g1);
    @(posedge clk); #1;
    pv  = {pv[1:0], pend_v};
    pid = {pid[1:0], pend_id};
    pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = pend_d;
    if (pv[2]) begin
      if (pid[2]) e_rd1 = pd[2];
      else        e_rd0 = pd[2];
    end
    e_g0 = g0; e_g1 = g1;
    pend_v = g0 | g1; pend_id = g1; pend_d = g1 ? ram[a1] : ram[a0];
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; hold = h;
    #2;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; hold = 0; addr0 = 0; addr1 = 0;
    req0_b = 0; req1_b = 0; hold_b = 0; addr0_b = 0; addr1_b = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 8'h55; req1 = 0; addr1 = 0; hold = 0;
    req0_b = 1'b1; addr0_b = 8'h55; req1_b = 0; addr1_b = 0; hold_b = 0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (mem_addr !== 8'h00) begin
      n_bad++; $display("FAIL reset mem_addr: got %h want 00", mem_addr);
    end
    n_cmp++;
    if ({rvalid0, rvalid1, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset flags: got %b want 000", {rvalid0, rvalid1, busy});
    end
    n_cmp++;
    if ({rdata0, rdata1} !== 16'h0000) begin
      n_bad++; $display("FAIL reset rdata: got %h want 0000", {rdata0, rdata1});
    end
    n_cmp++;
    if ({rvalid0_b, busy_b, mem_addr_b} !== 10'h000) begin
      n_bad++; $display("FAIL reset lat2: got %h want 000", {rvalid0_b, busy_b, mem_addr_b});
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      else        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL single cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      if (c == 1) begin
        n_cmp++;
        if (mem_addr !== 8'h10) begin
          n_bad++; $display("FAIL single mem_addr: got %h want 10", mem_addr);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({rvalid0, rdata0} !== {1'b1, 8'hA5}) begin
          n_bad++; $display("FAIL single rdata0: got %b/%h want 1/a5", rvalid0, rdata0);
        end
      end
    end
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    logic r0, r1, g0, g1;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      r0 = (i0 < 8);
      r1 = (i1 < 8);
      // Both held: strict alternation starting with client 0.
      g0 = r0 && (!r1 || (c % 2 == 0));
      g1 = r1 && !g0;
      cycle(r0, 8'(i0), r1, 8'(8'h80 + i1), 1'b0, g0, g1);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL contention cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
      if (g0) i0++;
      if (g1) i1++;
    end
  endtask

  task automatic test_stream();
    int n_g1 = 0;
    apply_reset();
    for (int c = 0; c < 256; c++) begin
      cycle(1'b0, 8'h00, 1'b1, 8'(c), 1'b0, 1'b0, 1'b1);
      if (gnt1) n_g1++;
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL stream cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    // Pointer must still favour client 0 after uncontested grants.
    cycle(1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin
      n_bad++; $display("FAIL stream contested: got %h want %h", obs_vec, exp_vec);
    end
    cycle(1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL stream drain %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    n_cmp++;
    if (n_g1 !== 256) begin
      n_bad++; $display("FAIL stream gnt1 count: got %0d want 256", n_g1);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      if (c == 0)      cycle(1'b1, 8'h21, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      else if (c == 1) cycle(1'b0, 8'h00, 1'b1, 8'h91, 1'b0, 1'b0, 1'b1);
      else if (c < 7)  cycle(1'b1, 8'h22, 1'b1, 8'h92, 1'b1, 1'b0, 1'b0);
      else if (c == 7) cycle(1'b1, 8'h22, 1'b1, 8'h92, 1'b0, 1'b1, 1'b0);
      else if (c == 8) cycle(1'b0, 8'h00, 1'b1, 8'h92, 1'b0, 1'b0, 1'b1);
      else             cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL hold cyc %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({obs_vec, mem_addr} !== {exp_vec, 8'h81}) begin
      n_bad++; $display("FAIL midflight pre: got %h want %h", {obs_vec, mem_addr}, {exp_vec, 8'h81});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid0, rvalid1, busy, mem_addr, rdata0, rdata1} !== 27'h0) begin
      n_bad++;
      $display("FAIL midflight async: got %h want 0",
               {rvalid0, rvalid1, busy, mem_addr, rdata0, rdata1});
    end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL midflight post %0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_lat2();
    logic e_rv, e_busy;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      req0_b  = (c == 0);
      addr0_b = (c == 0) ? 8'h10 : 8'h00;
      #2;
      e_rv   = (c == 4);
      e_busy = (c >= 1) && (c <= 4);
      n_cmp++;
      if ({gnt0_b, rvalid0_b, busy_b} !== {(c == 0), e_rv, e_busy}) begin
        n_bad++;
        $display("FAIL lat2 cyc %0d: got %b want %b", c, {gnt0_b, rvalid0_b, busy_b},
                 {(c == 0), e_rv, e_busy});
      end
      if (c >= 4) begin
        n_cmp++;
        if (rdata0_b !== 8'hA5) begin
          n_bad++; $display("FAIL lat2 rdata0 cyc %0d: got %h want a5", c, rdata0_b);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 8'(k * 37 + 11);
    ram[8'h10] = 8'hA5;
    model_clear();
    test_reset();
    test_single_read();
    test_contention();
    test_stream();
    test_hold();
    test_reset_midflight();
    test_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s_mem_read_port.md
# s_mem_read_port

Two-client read arbiter and responder for the 256×8 on-chip working memory. This is the read-side counterpart of the write-path selection logic. It accepts read requests from two independent client FSMs (e.g. the swap and keystream stages) and arbitrates them round-robin onto a single RAM address port. It returns each byte to the requesting client with a one-cycle valid pulse after a fixed pipeline latency, sustaining one read per cycle.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in cycles from address capture to q valid (legal 1..3)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hold  in  1  while high, no new grants; in-flight reads still complete
- req0  in  1  client 0 read request; held with addr0 stable until gnt0
- addr0  in  ADDR_W  client 0 read address
- gnt0  out  1  combinational; request accepted this cycle when req0 && gnt0
- rvalid0  out  1  one-cycle pulse, rdata0 valid
- rdata0  out  DATA_W  returned byte for client 0
- req1, addr1, gnt1, rvalid1, rdata1: same meanings for client 1
- mem_addr  out  ADDR_W  registered RAM address
- mem_q  in  DATA_W  RAM read data
- busy  out  1  high while any accepted read has not yet returned rvalid

## Operation
- Arbitration: if hold=0 and exactly one req is high, grant that client. If both are high, grant the client pointed to by rr_ptr. rr_ptr then flips to the other client only on a contested grant; an uncontested grant leaves it unchanged.
- At most one gnt is high per cycle; gnt is never high without the matching req, and is never high while hold=1.
- On accept: mem_addr <= granted address. Push {valid=1, id} into tag shift register of depth RD_LAT+1; otherwise push {valid=0}.
- Tag pipeline output with valid=1: capture mem_q into rdata[id] and pulse rvalid[id] next cycle. The other client's rdata holds its previous value.
- mem_addr holds its last value when no grant.
- busy = OR of all tag valid bits and both rvalid registers.
- Reset (async, any time): rr_ptr=0 (client 0 favoured), mem_addr=0, all tags invalid, rvalid0/1=0, rdata0/1=0. In-flight reads are dropped silently; busy=0.

## Timing
- Cycle 0: req&&gnt sampled at end of cycle. Cycle 1: mem_addr valid. Cycle 1+RD_LAT: mem_q valid. Cycle 2+RD_LAT: rvalidN high.
- Latency fixed at RD_LAT+2 cycles (3 at default), independent of contention.
- Throughput: one accepted read per cycle in aggregate. Back-to-back reads return in accept order, one rvalid per cycle, never both rvalid0 and rvalid1 in the same cycle.
- A hold asserted in cycle N blocks grants in cycle N (combinational). Reads accepted before cycle N still return on schedule.
- req dropped before gnt: no read issued, no response.
- Address wrap: 8'hFF is an ordinary address; no arithmetic on addresses.

## Structure
- Package s_mem_pkg: ADDR_W/DATA_W defaults, typedef client_id_t (1 bit), typedef rd_tag_t {logic valid; client_id_t id;}.
- Sub-module rr_arb2: combinational two-way round-robin grant plus registered rr_ptr update; inputs req[1:0], hold; outputs gnt[1:0], contested grant strobe.
- Top: address register, tag shift register (generate over RD_LAT+1), response demux registers.

## Test plan
- Reset, single read: preload RAM[8'h10]=8'hA5; req0 with addr0=8'h10 for one cycle -> gnt0 in cycle 0, rvalid0 pulse in cycle 3 with rdata0=8'hA5, busy high cycles 1–3.
- Contention: req0 and req1 held continuously with addresses 0x00..0x07 and 0x80..0x87 -> grants alternate starting with client 0. Responses return in grant order, one per cycle, each with the correct byte and no simultaneous rvalids.
- Uncontested stream: req1 only, 256 addresses 0x00..0xFF back-to-back -> 256 gnt1, rvalid1 on consecutive cycles including address 0xFF. rr_ptr stays at 0, so the next contested grant goes to client 0.
- Hold: issue 2 reads, then assert hold for 5 cycles with both reqs high -> no gnt during hold, both earlier reads return on schedule, grants resume the cycle hold drops.
- Reset mid-flight: accept reads at cycles 0 and 1, pull rst_n low at cycle 2 -> rvalid0/1, busy, mem_addr, and rdata go to 0 immediately, and no rvalid appears after reset release.
- RD_LAT=2 build: repeat the single-read case -> rvalid0 in cycle 4.
